// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the five-stage pipeline.
// Produces the load-enable and flush controls for the PC register and the
// F/D, D/X, X/M and M/W latches. It detects load-use hazards, holds the
// front of the pipe while the multicycle mult/div unit runs, squashes the
// wrong path on a taken branch, and counts stall and flush cycles.

module pipeline_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic [31:0]      fd_ir,
    input  logic [31:0]      dx_ir,
    input  logic             branch_taken,
    input  logic             md_ready,
    output logic             pc_en,
    output logic             fd_en,
    output logic             dx_en,
    output logic             xm_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             dx_flush,
    output logic             xm_flush,
    output logic             md_start,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    // ------------------------------------------------------------------
    // Instruction encoding
    // ------------------------------------------------------------------
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // ------------------------------------------------------------------
    // Field decode
    // ------------------------------------------------------------------
    logic [4:0] fd_opcode;
    logic [4:0] fd_rd;
    logic [4:0] fd_rs;
    logic [4:0] fd_rt;
    logic [4:0] dx_opcode;
    logic [4:0] dx_rd;
    logic [4:0] dx_aluop;

    assign fd_opcode = fd_ir[31:27];
    assign fd_rd     = fd_ir[26:22];
    assign fd_rs     = fd_ir[21:17];
    assign fd_rt     = fd_ir[16:12];
    assign dx_opcode = dx_ir[31:27];
    assign dx_rd     = dx_ir[26:22];
    assign dx_aluop  = dx_ir[6:2];

    // Fields the controller never looks at (shamt, low bits, D/X sources).
    logic unused_fields;
    assign unused_fields = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

    // ------------------------------------------------------------------
    // Hazard classification
    // ------------------------------------------------------------------
    logic dx_is_lw;
    logic dx_is_md;
    logic fd_reads_rt;
    logic fd_reads_rd;
    logic load_use;

    // A load into r0 produces nothing to wait for.
    assign dx_is_lw = (dx_opcode == OP_LW) && (dx_rd != 5'd0);
    assign dx_is_md = (dx_opcode == OP_RTYPE) &&
                      ((dx_aluop == ALU_MUL) || (dx_aluop == ALU_DIV));

    // rs is always a source; R-types also read rt; stores, compare
    // branches and jr read the register named in the rd slot.
    assign fd_reads_rt = (fd_opcode == OP_RTYPE);
    assign fd_reads_rd = (fd_opcode == OP_SW)  || (fd_opcode == OP_BNE) ||
                         (fd_opcode == OP_BLT) || (fd_opcode == OP_JR);

    assign load_use = dx_is_lw &&
                      ((dx_rd == fd_rs) ||
                       (fd_reads_rt && (dx_rd == fd_rt)) ||
                       (fd_reads_rd && (dx_rd == fd_rd)));

    // ------------------------------------------------------------------
    // Mult/div sequencer
    // ------------------------------------------------------------------
    md_state_t state;
    logic      md_hold;
    logic      md_release;

    // The start cycle already holds the pipe; BUSY keeps holding until the
    // cycle md_ready arrives, which is the release cycle.
    assign md_hold    = ((state == IDLE) && dx_is_md) ||
                        ((state == BUSY) && !md_ready);
    assign md_release = (state == BUSY) && md_ready;

    // FSM: IDLE waits for a mul/div in D/X, BUSY waits for md_ready.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state is written with non-blocking assignments
            // so every flop samples pre-edge values, independent of block order.
            unique case (state)
                IDLE:    if (dx_is_md) state <= BUSY;
                BUSY:    if (md_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign md_busy = (state == BUSY);

    // ------------------------------------------------------------------
    // Latch controls
    // ------------------------------------------------------------------
    logic flush_win;

    // Prioritised latch controls: mult/div hold, branch squash, load-use
    // bubble, then free-running.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // if/else chain leaves one unassigned and infers a latch.
        pc_en     = 1'b1;
        fd_en     = 1'b1;
        dx_en     = 1'b1;
        xm_en     = 1'b1;
        mw_en     = 1'b1;
        fd_flush  = 1'b0;
        dx_flush  = 1'b0;
        xm_flush  = 1'b0;
        md_start  = 1'b0;
        flush_win = 1'b0;

        if (ctrl_reset) begin
            pc_en = 1'b0;
            fd_en = 1'b0;
            dx_en = 1'b0;
            xm_en = 1'b0;
            mw_en = 1'b0;
        end else if (md_hold) begin
            // Freeze PC, F/D, D/X; keep a bubble flowing into X/M.
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            dx_en    = 1'b0;
            xm_flush = 1'b1;
            md_start = (state == IDLE);
        end else if (branch_taken) begin
            // Wrong-path instructions in F/D and D/X become nops.
            fd_flush  = 1'b1;
            dx_flush  = 1'b1;
            flush_win = 1'b1;
        end else if (load_use) begin
            // One bubble: hold the consumer while the load moves to X/M.
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            dx_flush = 1'b1;
        end
        // On md_release everything advances and X/M captures the mult/div
        // result, which the default (no flush) already provides.
    end

    logic unused_release;
    assign unused_release = md_release;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------

    // Saturating count of cycles where the PC is frozen.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            stall_cycles <= '0;
        end else if (!pc_en && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + CNT_ONE;
        end
    end

    // Saturating count of cycles where a taken branch squashes the front.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            flush_cycles <= '0;
        end else if (flush_win && (flush_cycles != CNT_MAX)) begin
            flush_cycles <= flush_cycles + CNT_ONE;
        end
    end

endmodule
